key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_pkg.sv | 14 +
 rtl/key_debounce_ch.sv | 98 +++++++++
 rtl/key_debounce.sv | 33 +++
 tb/tb_key_debounce.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared encodings and defaults for the two-key pushbutton debouncer.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    WAIT_PRESS   = 2'b01,
    PRESSED      = 2'b10,
    WAIT_RELEASE = 2'b11
  } kstate_e;

  localparam logic        KEY_RELEASED            = 1'b1;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter, 4-state FSM, press pulse.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_raw_i,
  output logic key_o,
  output logic press_o
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta_q;
  logic             sync_q;
  kstate_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_q, key_d;
  logic             press_q, press_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_meta_q <= KEY_RELEASED;
      sync_q      <= KEY_RELEASED;
      state_q     <= RELEASED;
      cnt_q       <= '0;
      key_q       <= KEY_RELEASED;
      press_q     <= 1'b0;
    end else begin
      sync_meta_q <= key_raw_i;
      sync_q      <= sync_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      press_q     <= press_d;
    end
  end

  // Counter tops out at DEBOUNCE_CYCLES-1, where the FSM leaves the wait state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (sync_q != KEY_RELEASED) begin
          state_d = WAIT_PRESS;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_PRESS: begin
        if (sync_q == KEY_RELEASED) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (sync_q == KEY_RELEASED) begin
          state_d = WAIT_RELEASE;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_RELEASE: begin
        if (sync_q != KEY_RELEASED) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Output and pulse are registered from the next state so they line up with state_q.
  always_comb begin
    key_d   = ((state_d == RELEASED) || (state_d == WAIT_PRESS)) ? KEY_RELEASED : ~KEY_RELEASED;
    press_d = (key_q == KEY_RELEASED) && (key_d != KEY_RELEASED);
  end

  assign key_o   = key_q;
  assign press_o = press_q;

endmodule

// File: rtl/key_debounce.sv
// Two independent debounced active-low pushbuttons with one-cycle press pulses.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic Key1_raw,
  input  logic Key2_raw,
  output logic Key1,
  output logic Key2,
  output logic Key1_press,
  output logic Key2_press
);

  key_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .clk_i     (clock),
    .rst_i     (reset),
    .key_raw_i (Key1_raw),
    .key_o     (Key1),
    .press_o   (Key1_press)
  );

  key_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key2 (
    .clk_i     (clock),
    .rst_i     (reset),
    .key_raw_i (Key2_raw),
    .key_o     (Key2),
    .press_o   (Key2_press)
  );

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed latency/bounce/reset cases plus random bouncing vs. a run-length model.
module tb_key_debounce;

  localparam int N = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic Key1_raw = 1'b1;
  logic Key2_raw = 1'b1;
  logic Key1, Key2, Key1_press, Key2_press;

  int checks = 0;
  int errors = 0;

  key_debounce #(.DEBOUNCE_CYCLES(N)) dut (
    .clock      (clock),
    .reset      (reset),
    .Key1_raw   (Key1_raw),
    .Key2_raw   (Key2_raw),
    .Key1       (Key1),
    .Key2       (Key2),
    .Key1_press (Key1_press),
    .Key2_press (Key2_press)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a key level flips once the synchronized input has differed from it for N straight cycles.
  bit m_ok = 0;
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_lvl [2];
  bit m_pulse [2];
  int m_run [2];

  always @(posedge clock) begin
    bit raw [2];
    raw[0] = Key1_raw;
    raw[1] = Key2_raw;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_lvl[k] = 1'b1; m_pulse[k] = 1'b0; m_run[k] = 0;
      end else begin
        m_pulse[k] = 1'b0;
        if (m_s2[k] != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == N) begin
            m_lvl[k]   = ~m_lvl[k];
            m_run[k]   = 0;
            m_pulse[k] = (m_lvl[k] == 1'b0);
          end
        end else begin
          m_run[k] = 0;
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = raw[k];
      end
    end
    if (reset) m_ok = 1'b1;
  end

  always @(negedge clock) begin
    if (m_ok) begin
      chk("model_key1",   int'(Key1),       int'(m_lvl[0]));
      chk("model_key2",   int'(Key2),       int'(m_lvl[1]));
      chk("model_press1", int'(Key1_press), int'(m_pulse[0]));
      chk("model_press2", int'(Key2_press), int'(m_pulse[1]));
    end
  end

  // Cycles (negedges) until the selected key output reads lvl; 40 means the bound expired.
  task automatic wait_key(input int k, input bit lvl, output int cyc, output int p1, output int p2);
    cyc = 40; p1 = 0; p2 = 0;
    for (int i = 1; i < 40; i++) begin
      @(negedge clock);
      if (((k == 0) ? Key1 : Key2) == lvl) begin
        cyc = i; p1 = Key1_press; p2 = Key2_press;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  initial begin
    int cyc, p1, p2, pulses, hi;
    int hold [2];

    idle(2);
    reset = 1'b0;
    chk("reset_key1", int'(Key1), 1);
    chk("reset_key2", int'(Key2), 1);
    chk("reset_press", int'(Key1_press) + int'(Key2_press), 0);
    idle(3);

    // Clean press on Key1
    Key1_raw = 1'b0;
    wait_key(0, 1'b0, cyc, p1, p2);
    chk("press_latency", cyc, 6);
    chk("press_pulse", p1, 1);
    chk("press_key2_idle", int'(Key2), 1);
    @(negedge clock);
    chk("press_pulse_one_cycle", int'(Key1_press), 0);
    idle(14);

    // Release Key1: no pulse expected
    Key1_raw = 1'b1;
    pulses = 0; cyc = 40;
    for (int i = 1; i < 40; i++) begin
      @(negedge clock);
      pulses += int'(Key1_press);
      if (Key1 == 1'b1) begin cyc = i; break; end
    end
    chk("release_latency", cyc, 6);
    chk("release_no_pulse", pulses, 0);
    idle(4);

    // Bounce on Key2
    pulses = 0; hi = 0;
    for (int i = 0; i < 4; i++) begin
      Key2_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
      @(negedge clock);
      pulses += int'(Key2_press);
      hi += int'(Key2);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      pulses += int'(Key2_press);
      hi += int'(Key2);
    end
    chk("bounce_key2_high_cycles", hi, 16);
    chk("bounce_no_pulse", pulses, 0);

    // Simultaneous press
    Key1_raw = 1'b0; Key2_raw = 1'b0;
    wait_key(0, 1'b0, cyc, p1, p2);
    chk("simul_latency", cyc, 6);
    chk("simul_key2", int'(Key2), 0);
    chk("simul_pulses", p1 + p2, 2);
    idle(4);
    Key1_raw = 1'b1; Key2_raw = 1'b1;
    idle(10);

    // Reset mid-debounce
    Key1_raw = 1'b0;
    idle(3);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    wait_key(0, 1'b0, cyc, p1, p2);
    chk("reset_abort_latency", cyc, 6);
    chk("reset_abort_pulse", p1, 1);
    Key1_raw = 1'b1;
    idle(10);

    // Random bouncing on both keys, occasional reset
    hold[0] = 0; hold[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold[0] == 0) begin Key1_raw = 1'($urandom_range(0, 1)); hold[0] = $urandom_range(1, 8); end
      if (hold[1] == 0) begin Key2_raw = 1'($urandom_range(0, 1)); hold[1] = $urandom_range(1, 8); end
      hold[0]--; hold[1]--;
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clock);
    end
    reset = 1'b0;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
